// File: rtl/uart_hex_framer_pkg.sv
// rtl/uart_hex_framer_pkg.sv - shared constants, FSM state type and nibble-to-ASCII helper
package uart_hex_framer_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_e;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return ASCII_0 + {4'h0, n};
        end
        return ASCII_A + {4'h0, n - 4'd10};
    endfunction

endpackage

// File: rtl/uart_hex_framer_hex_nibble_ascii.sv
// rtl/uart_hex_framer_hex_nibble_ascii.sv - combinational 4-bit to uppercase ASCII hex digit
module hex_nibble_ascii
    import uart_hex_framer_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    assign ascii = nibble_to_ascii(nibble);

endmodule

// File: rtl/uart_hex_framer.sv
// rtl/uart_hex_framer.sv - formats one sample as ASCII hex plus EOL, one byte per transmitter handshake
module uart_hex_framer
    import uart_hex_framer_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter bit EOL_CRLF = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              tx_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic [15:0]       frames_sent
);

    localparam int NDIG  = DATA_W / 4;
    localparam int NCHR  = NDIG + (EOL_CRLF ? 2 : 1);
    localparam int IDX_W = $clog2(NCHR);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHR - 1);
    localparam logic [IDX_W-1:0] IDX_NDIG = IDX_W'(NDIG);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [15:0]       frames_sent_q, frames_sent_d;
    logic              in_ready_q, in_ready_d;
    logic              tx_start_q, tx_start_d;

    logic [3:0]        nib;
    logic [7:0]        hex_char;
    logic [7:0]        cur_char;

    // Character mux: hex digits MS nibble first, then the line terminator.
    always_comb begin
        nib = 4'h0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib = sample_q[DATA_W-1-4*i -: 4];
            end
        end
    end

    hex_nibble_ascii u_hex (
        .nibble (nib),
        .ascii  (hex_char)
    );

    always_comb begin
        if (idx_q < IDX_NDIG) begin
            cur_char = hex_char;
        end else if (EOL_CRLF && (idx_q == IDX_NDIG)) begin
            cur_char = ASCII_CR;
        end else begin
            cur_char = ASCII_LF;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        sample_d      = sample_q;
        tx_data_d     = tx_data_q;
        frames_sent_d = frames_sent_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sample_d = in_data;
                    idx_d    = '0;
                    state_d  = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (tx_ready) begin
                    tx_data_d = cur_char;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                // tx_ready low means the transmitter has taken the byte
                if (!tx_ready) begin
                    if (idx_q == IDX_LAST) begin
                        frames_sent_d = frames_sent_q + 16'd1;
                        state_d       = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_WAIT_HI;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d = (state_d == ST_IDLE);
        tx_start_d = (state_d == ST_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            sample_q      <= '0;
            tx_data_q     <= 8'h00;
            frames_sent_q <= 16'h0000;
            in_ready_q    <= 1'b1;
            tx_start_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            sample_q      <= sample_d;
            tx_data_q     <= tx_data_d;
            frames_sent_q <= frames_sent_d;
            in_ready_q    <= in_ready_d;
            tx_start_q    <= tx_start_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = !in_ready_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_uart_hex_framer.sv
// tb/tb_uart_hex_framer.sv - directed bench: CRLF and LF-only framers each driving a transmitter model
module tb_uart_hex_framer;

    localparam int TX_CYC = 6;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid    [2];
    logic [15:0] in_data     [2];
    logic        in_ready    [2];
    logic        tx_ready    [2] = '{1'b1, 1'b1};
    logic        tx_start    [2];
    logic [7:0]  tx_data     [2];
    logic        busy        [2];
    logic [15:0] frames_sent [2];

    int          tx_cnt      [2] = '{0, 0};
    int          starts      [2] = '{0, 0};
    int          accepts     [2] = '{0, 0};
    logic        prev_start  [2] = '{1'b0, 1'b0};
    logic [7:0]  rx0 [$];
    logic [7:0]  rx1 [$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_hex_framer #(.DATA_W(16), .EOL_CRLF(1'b1)) dut0 (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid[0]),
        .in_data     (in_data[0]),
        .in_ready    (in_ready[0]),
        .tx_ready    (tx_ready[0]),
        .tx_start    (tx_start[0]),
        .tx_data     (tx_data[0]),
        .busy        (busy[0]),
        .frames_sent (frames_sent[0])
    );

    uart_hex_framer #(.DATA_W(16), .EOL_CRLF(1'b0)) dut1 (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid[1]),
        .in_data     (in_data[1]),
        .in_ready    (in_ready[1]),
        .tx_ready    (tx_ready[1]),
        .tx_start    (tx_start[1]),
        .tx_data     (tx_data[1]),
        .busy        (busy[1]),
        .frames_sent (frames_sent[1])
    );

    // Transmitter model: takes a byte on tx_start, stays busy TX_CYC cycles.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (tx_start[k]) begin
                if (k == 0) rx0.push_back(tx_data[k]);
                else        rx1.push_back(tx_data[k]);
                starts[k]   <= starts[k] + 1;
                tx_ready[k] <= 1'b0;
                tx_cnt[k]   <= TX_CYC;
            end else if (tx_cnt[k] > 0) begin
                tx_cnt[k] <= tx_cnt[k] - 1;
                if (tx_cnt[k] == 1) tx_ready[k] <= 1'b1;
            end
            if (rstn && in_valid[k] && in_ready[k]) accepts[k] <= accepts[k] + 1;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (tx_start[k]) begin
                n_checks++;
                assert (tx_ready[k] === 1'b1) else begin
                    n_fail++;
                    $error("FAIL start_while_busy dut%0d: tx_ready=%0b required 1", k, tx_ready[k]);
                end
                n_checks++;
                assert (prev_start[k] === 1'b0) else begin
                    n_fail++;
                    $error("FAIL start_width dut%0d: tx_start high two cycles, required one", k);
                end
            end
            prev_start[k] = tx_start[k];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int k, input logic [15:0] data);
        in_valid[k] = 1'b1;
        in_data[k]  = data;
        @(negedge clk);
        in_valid[k] = 1'b0;
        in_data[k]  = 16'h5A5A;
    endtask

    task automatic wait_idle(input string tag, input int k, input logic [15:0] target);
        logic done;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            done = (frames_sent[k] == target) && in_ready[k] && tx_ready[k];
        end
        chk({tag, "_timeout"}, {31'd0, done}, 32'd1);
    endtask

    task automatic check_bytes(input string tag, input int k, input int base, input string exp);
        int n;
        logic [7:0] b;
        n = (k == 0) ? rx0.size() : rx1.size();
        chk({tag, "_len"}, n - base, exp.len());
        for (int i = 0; i < exp.len(); i++) begin
            b = (k == 0) ? rx0[base+i] : rx1[base+i];
            chk({tag, "_byte"}, {24'd0, b}, {24'd0, exp[i]});
        end
    endtask

    initial begin
        int base;
        int acc0;
        int st0;
        logic hit;

        rstn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0;
            in_data[k]  = 16'h0000;
        end
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready[0]}, 32'd1);
        chk("rst_busy", {31'd0, busy[0]}, 32'd0);
        chk("rst_tx_start", {31'd0, tx_start[0]}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data[0]}, 32'h00);
        chk("rst_frames", {16'd0, frames_sent[0]}, 32'd0);
        chk("rst_frames_lf", {16'd0, frames_sent[1]}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // A5F0 with CR LF, plus accept-to-start latency
        in_valid[0] = 1'b1;
        in_data[0]  = 16'hA5F0;
        @(negedge clk);
        chk("t1_in_ready", {31'd0, in_ready[0]}, 32'd0);
        chk("t1_busy", {31'd0, busy[0]}, 32'd1);
        chk("t1_no_start_yet", {31'd0, tx_start[0]}, 32'd0);
        in_valid[0] = 1'b0;
        in_data[0]  = 16'h1111;
        @(negedge clk);
        chk("t1_start_latency", {31'd0, tx_start[0]}, 32'd1);
        chk("t1_first_char", {24'd0, tx_data[0]}, 32'h41);
        wait_idle("t1", 0, 16'd1);
        check_bytes("t1", 0, 0, "A5F0\r\n");
        chk("t1_frames", {16'd0, frames_sent[0]}, 32'd1);

        // LF-only framer
        st0 = starts[1];
        send(1, 16'h0009);
        wait_idle("t2", 1, 16'd1);
        check_bytes("t2", 1, 0, "0009\n");
        chk("t2_starts", starts[1] - st0, 32'd5);

        // in_valid held across two frames
        base = rx0.size();
        acc0 = accepts[0];
        in_valid[0] = 1'b1;
        in_data[0]  = 16'h1234;
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            hit = (accepts[0] == acc0 + 1);
        end
        chk("t3_accept1", {31'd0, hit}, 32'd1);
        in_data[0] = 16'hFFFF;
        hit = 1'b0;
        for (int c = 0; c < 1000 && !hit; c++) begin
            @(negedge clk);
            hit = (accepts[0] == acc0 + 2);
        end
        chk("t3_accept2", {31'd0, hit}, 32'd1);
        in_valid[0] = 1'b0;
        wait_idle("t3", 0, 16'd3);
        chk("t3_accept_count", accepts[0] - acc0, 32'd2);
        check_bytes("t3", 0, base, "1234\r\nFFFF\r\n");

        // reset after the second character of BEEF
        base = rx0.size();
        send(0, 16'hBEEF);
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            hit = (rx0.size() == base + 2);
        end
        chk("t5_two_chars", {31'd0, hit}, 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        chk("t5_in_ready", {31'd0, in_ready[0]}, 32'd1);
        chk("t5_tx_start", {31'd0, tx_start[0]}, 32'd0);
        chk("t5_busy", {31'd0, busy[0]}, 32'd0);
        chk("t5_frames", {16'd0, frames_sent[0]}, 32'd0);
        chk("t5_tx_data", {24'd0, tx_data[0]}, 32'h00);
        rstn = 1'b1;
        check_bytes("t5_pre", 0, base, "BE");
        send(0, 16'h00C3);
        wait_idle("t5", 0, 16'd1);
        check_bytes("t5", 0, base + 2, "00C3\r\n");

        // frame counter wrap from FFFF
        base = rx0.size();
        force dut0.frames_sent_q = 16'hFFFF;
        @(negedge clk);
        release dut0.frames_sent_q;
        @(negedge clk);
        chk("t6_preset", {16'd0, frames_sent[0]}, 32'h0000FFFF);
        send(0, 16'h7E01);
        wait_idle("t6", 0, 16'h0000);
        chk("t6_wrap", {16'd0, frames_sent[0]}, 32'd0);
        check_bytes("t6", 0, base, "7E01\r\n");

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
